// File: rtl/mem_bus_bridge.sv
// MEM-stage to memory-bus bridge: IDLE/BUS/DONE handshake FSM that stalls the pipeline per access.
// Optional bus timeout abort is compiled in with `define BUS_TIMEOUT_EN.
module mem_bus_bridge #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_error,
  output logic        CPU_MIO,
  output logic        mem_w,
  output logic [31:0] Address_out,
  output logic [31:0] Data_out,
  input  logic [31:0] Data_in,
  input  logic        MIO_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          we_d    = cpu_we;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = BUS;
        end
      end
      BUS: begin
        // A ready response wins over a timeout reached in the same cycle.
        if (MIO_ready) begin
          if (!we_q) begin
            rdata_d = Data_in;
          end
          state_d = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYCLES) begin
          if (!we_q) begin
            rdata_d = '0;
          end
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall drops only in DONE, so the request cycle itself already stalls.
  assign cpu_stall   = cpu_req && (state_q != DONE);
  assign CPU_MIO     = (state_q == BUS);
  assign mem_w       = (state_q == BUS) && we_q;
  assign Address_out = addr_q;
  assign Data_out    = wdata_q;
  assign cpu_rdata   = rdata_q;

`ifdef BUS_TIMEOUT_EN
  assign bus_error = err_q;
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed self-checking bench for mem_bus_bridge; timeout cases run only with BUS_TIMEOUT_EN.
module tb_mem_bus_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_error;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Address_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;

  int n_total = 0;
  int n_bad   = 0;
  int stall_cycles;
  int wbus_cycles;

  mem_bus_bridge #(
    .TIMEOUT_CYCLES(8'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .bus_error  (bus_error),
    .CPU_MIO    (CPU_MIO),
    .mem_w      (mem_w),
    .Address_out(Address_out),
    .Data_out   (Data_out),
    .Data_in    (Data_in),
    .MIO_ready  (MIO_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    Data_in   = '0;
    MIO_ready = 1'b0;
    #2;
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_addr", Address_out, 32'h0);
    chk("rst_dout", Data_out, 32'h0);
    chk("rst_mio", {31'b0, CPU_MIO}, 32'h0);
    chk("rst_memw", {31'b0, mem_w}, 32'h0);
    chk("rst_err", {31'b0, bus_error}, 32'h0);
    tick();
    tick();
    rst = 1'b1;

    // Load, issued in the first cycle after reset release
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF;
    settle();
    chk("ld_stall_req", {31'b0, cpu_stall}, 32'h1);
    chk("ld_mio_req", {31'b0, CPU_MIO}, 32'h0);
    tick();
    chk("ld_mio_bus", {31'b0, CPU_MIO}, 32'h1);
    chk("ld_memw_bus", {31'b0, mem_w}, 32'h0);
    chk("ld_addr_bus", Address_out, 32'h0000_0010);
    chk("ld_stall_bus", {31'b0, cpu_stall}, 32'h1);
    MIO_ready = 1'b1; Data_in = 32'hCAFE_F00D;
    tick();
    chk("ld_stall_done", {31'b0, cpu_stall}, 32'h0);
    chk("ld_mio_done", {31'b0, CPU_MIO}, 32'h0);
    chk("ld_rdata_done", cpu_rdata, 32'hCAFE_F00D);
    chk("ld_err_done", {31'b0, bus_error}, 32'h0);
    cpu_req = 1'b0; MIO_ready = 1'b0;
    tick();

    // Ready outside BUS must not touch read data
    MIO_ready = 1'b1; Data_in = 32'hBAD0_BAD0;
    tick();
    chk("idle_ready_ignored", cpu_rdata, 32'hCAFE_F00D);
    chk("idle_ready_mio", {31'b0, CPU_MIO}, 32'h0);
    MIO_ready = 1'b0;

    // Store with ready delayed by 3 cycles; CPU address wiggles to prove latching
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    Data_in = 32'h5555_AAAA;
    stall_cycles = 0;
    wbus_cycles  = 0;
    settle();
    if (cpu_stall) stall_cycles++;
    for (int i = 0; i < 4; i++) begin
      tick();
      cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'h0;
      settle();
      if (cpu_stall) stall_cycles++;
      if (CPU_MIO && mem_w && Data_out == 32'h1234_5678 && Address_out == 32'h20) wbus_cycles++;
      MIO_ready = (i == 3);
    end
    tick();
    chk("st_stall_cycles", stall_cycles, 32'd5);
    chk("st_wbus_cycles", wbus_cycles, 32'd4);
    chk("st_stall_done", {31'b0, cpu_stall}, 32'h0);
    chk("st_memw_done", {31'b0, mem_w}, 32'h0);
    chk("st_rdata_kept", cpu_rdata, 32'hCAFE_F00D);
    chk("st_dout_hold", Data_out, 32'h1234_5678);
    MIO_ready = 1'b0; cpu_req = 1'b0;
    tick();

    // Back-to-back: request held high through DONE
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    tick();
    chk("b2b_bus1", {31'b0, CPU_MIO}, 32'h1);
    MIO_ready = 1'b1; Data_in = 32'h1111_2222;
    tick();
    MIO_ready = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hA5A5_5A5A;
    settle();
    chk("b2b_done_mio", {31'b0, CPU_MIO}, 32'h0);
    chk("b2b_done_stall", {31'b0, cpu_stall}, 32'h0);
    chk("b2b_done_rdata", cpu_rdata, 32'h1111_2222);
    tick();
    chk("b2b_idle_mio", {31'b0, CPU_MIO}, 32'h0);
    chk("b2b_idle_stall", {31'b0, cpu_stall}, 32'h1);
    chk("b2b_idle_addr", Address_out, 32'h30);
    tick();
    chk("b2b_bus2_mio", {31'b0, CPU_MIO}, 32'h1);
    chk("b2b_bus2_memw", {31'b0, mem_w}, 32'h1);
    chk("b2b_bus2_addr", Address_out, 32'h40);
    MIO_ready = 1'b1; Data_in = 32'h9999_9999;
    tick();
    chk("b2b_st_rdata", cpu_rdata, 32'h1111_2222);
    cpu_req = 1'b0; MIO_ready = 1'b0;
    tick();

    // Reset asserted in the second BUS cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; cpu_wdata = 32'h7777_7777;
    tick();
    tick();
    chk("rma_bus2_mio", {31'b0, CPU_MIO}, 32'h1);
    rst = 1'b0;
    settle();
    chk("rma_mio", {31'b0, CPU_MIO}, 32'h0);
    chk("rma_addr", Address_out, 32'h0);
    chk("rma_dout", Data_out, 32'h0);
    chk("rma_rdata", cpu_rdata, 32'h0);
    chk("rma_err", {31'b0, bus_error}, 32'h0);
    cpu_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rma_post_mio", {31'b0, CPU_MIO}, 32'h0);
    chk("rma_post_err", {31'b0, bus_error}, 32'h0);
    cpu_req = 1'b1; cpu_addr = 32'h60;
    tick();
    chk("rma_new_mio", {31'b0, CPU_MIO}, 32'h1);
    chk("rma_new_addr", Address_out, 32'h60);
    MIO_ready = 1'b1; Data_in = 32'h0000_600D;
    tick();
    chk("rma_new_rdata", cpu_rdata, 32'h0000_600D);
    chk("rma_new_err", {31'b0, bus_error}, 32'h0);
    cpu_req = 1'b0; MIO_ready = 1'b0;
    tick();

`ifdef BUS_TIMEOUT_EN
    // Timeout with TIMEOUT_CYCLES=4: abort after 5 BUS cycles
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h70;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("to_bus_mio", {31'b0, CPU_MIO}, 32'h1);
    end
    tick();
    chk("to_err", {31'b0, bus_error}, 32'h1);
    chk("to_rdata", cpu_rdata, 32'h0);
    chk("to_stall", {31'b0, cpu_stall}, 32'h0);
    cpu_req = 1'b0;
    tick();
    chk("to_err_pulse", {31'b0, bus_error}, 32'h0);
    // Ready arriving on the very cycle the count is reached completes normally
    cpu_req = 1'b1; cpu_addr = 32'h74;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("tr_bus_mio", {31'b0, CPU_MIO}, 32'h1);
    end
    MIO_ready = 1'b1; Data_in = 32'h0000_0077;
    tick();
    chk("tr_err", {31'b0, bus_error}, 32'h0);
    chk("tr_rdata", cpu_rdata, 32'h0000_0077);
    cpu_req = 1'b0; MIO_ready = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 8'd64, the number of MIO_ready-low cycles before an abort; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cpu_req, input, 1 bit: the MEM stage requests a load or store; held stable while cpu_stall=1.
REQ-005 The block SHALL have port cpu_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port cpu_addr, input, 32 bits: the access address.
REQ-007 The block SHALL have port cpu_wdata, input, 32 bits: the store data.
REQ-008 The block SHALL have port cpu_rdata, output, 32 bits: the registered load data.
REQ-009 The block SHALL have port cpu_stall, output, 1 bit: freezes the pipeline while an access is outstanding.
REQ-010 The block SHALL have port bus_error, output, 1 bit: a one-cycle abort pulse.
REQ-011 The block SHALL have port CPU_MIO, output, 1 bit: the bus request.
REQ-012 The block SHALL have port mem_w, output, 1 bit: the bus write strobe.
REQ-013 The block SHALL have port Address_out, output, 32 bits: the bus address.
REQ-014 The block SHALL have port Data_out, output, 32 bits: the bus write data.
REQ-015 The block SHALL have port Data_in, input, 32 bits: the bus read data.
REQ-016 The block SHALL have port MIO_ready, input, 1 bit: bus completion, sampled only in state BUS.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUS and DONE.
REQ-018 In IDLE with cpu_req=1, the block SHALL latch cpu_we, cpu_addr and cpu_wdata into Address_out, Data_out and a write flag, and go to BUS next cycle.
REQ-019 cpu_stall SHALL be combinational and equal cpu_req AND (state != DONE), so it is high in the request cycle with no bubble.
REQ-020 In BUS, CPU_MIO SHALL be 1, mem_w SHALL equal the latched write flag, and Address_out and Data_out SHALL hold their latched values.
REQ-021 In BUS with MIO_ready=1, the block SHALL capture Data_in into cpu_rdata on a load, leave cpu_rdata unchanged on a store, and go to DONE.
REQ-022 DONE SHALL last exactly one cycle with cpu_stall=0, CPU_MIO=0 and mem_w=0, and SHALL then return to IDLE unconditionally.
REQ-023 Minimum access latency SHALL be 2 stall cycles: request at cycle T, MIO_ready at T+1, release at T+2.
REQ-024 In IDLE and DONE, CPU_MIO and mem_w SHALL be 0, and Address_out and Data_out SHALL hold their last values.
REQ-025 MIO_ready SHALL be ignored outside BUS.
REQ-026 A cpu_req that stays high during DONE SHALL NOT start a new access until IDLE is reached.

Reset
REQ-027 While rst=0, the block SHALL immediately force: state IDLE, cpu_rdata=0, Address_out=0, Data_out=0, write flag=0, CPU_MIO=0, mem_w=0, bus_error=0, timeout counter=0.
REQ-028 Reset asserted during BUS SHALL abandon the access without a bus_error pulse.
REQ-029 The first access SHALL be accepted in the first cycle after rst rises.

Configuration
REQ-030 With macro BUS_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to BUS and increment each BUS cycle that has MIO_ready=0.
REQ-031 With BUS_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES with MIO_ready=0, the block SHALL go to DONE, set cpu_rdata=0 on a load, and pulse bus_error=1 for the DONE cycle.
REQ-032 With BUS_TIMEOUT_EN defined, MIO_ready=1 in the same cycle the count is reached SHALL complete normally with no error.
REQ-033 Without BUS_TIMEOUT_EN, BUS SHALL wait indefinitely, no counter SHALL exist, and bus_error SHALL be tied to 0.

Verification
REQ-034 Load: cpu_req=1, cpu_we=0, addr=0x0000_0010; MIO_ready=1 one cycle later with Data_in=0xCAFE_F00D -> CPU_MIO=1 for 1 cycle, mem_w=0, stall for 2 cycles, cpu_rdata=0xCAFE_F00D in the DONE cycle.
REQ-035 Store: addr=0x20, wdata=0x1234_5678, MIO_ready delayed 3 cycles -> mem_w=1 and Data_out=0x1234_5678 for 4 BUS cycles, stall for 5 cycles, cpu_rdata unchanged.
REQ-036 Back-to-back: cpu_req held high across two accesses -> DONE, IDLE and BUS observed in sequence; the second access starts exactly 1 cycle after DONE.
REQ-037 Reset mid-access: rst=0 on the second BUS cycle -> outputs are 0 within the same cycle; after release the state is IDLE and bus_error never pulses.
REQ-038 Timeout (BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4), MIO_ready held 0 -> DONE after 5 BUS cycles, bus_error=1 for 1 cycle, cpu_rdata=0; MIO_ready=1 on that same cycle -> no error.
